// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// SRAM-like data bus between the MEM-stage load/store sequencer (master)
// and the data memory or cache (slave).
//
// Handshake: the master raises data_req and holds data_wr, data_size,
// data_wstrb, data_addr and data_wdata stable until the slave answers
// with data_addr_ok; the request is accepted on the clock edge where
// data_req and data_addr_ok are both high. The transaction completes on
// the edge where data_data_ok is high: read data sits on data_rdata in
// that cycle, and for a write it marks completion. data_addr_ok and
// data_data_ok may arrive in the same cycle. At most one transaction is
// outstanding at any time.
//
// Signals:
//   data_req      master->slave  request valid
//   data_wr       master->slave  1 = write, 0 = read
//   data_size     master->slave  0 = byte, 1 = half, 2 = word
//   data_wstrb    master->slave  byte enables for writes
//   data_addr     master->slave  access address
//   data_wdata    master->slave  store data, replicated across lanes
//   data_addr_ok  slave->master  address accepted
//   data_data_ok  slave->master  read data returned / write completed
//   data_rdata    slave->master  read data
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Load/store sequencer for the MEM stage. Issues one bus transaction per
// valid, aligned load/store, stalls the pipeline while it is outstanding,
// generates store byte strobes, flags misaligned accesses and returns the
// size-selected, extended load word.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   memvalidM     MEM-stage instruction is a valid load/store
//   opM           opcode (LB/LH/LW/LBU/LHU/SB/SH/SW)
//   addrM         effective address
//   writedataM    store source value
//   flushM        flush of the MEM stage
//   stallM        hold the pipeline
//   loadresultM   extended load result, updated on each completed load
//   adelM/adesM   load/store address error
//   bus           data bus master port
//   state_dbg     current FSM state (IDLE=0 REQ=1 WAIT=2 DONE=3 DRAIN=4)
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memvalidM,
    input  logic [5:0]        opM,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [31:0]       writedataM,
    input  logic              flushM,
    output logic              stallM,
    output logic [31:0]       loadresultM,
    output logic              adelM,
    output logic              adesM,
    mem_access_ctrl_if.master bus,
    output logic [2:0]        state_dbg
);
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t state, state_next;

    // Decode of the instruction currently in MEM.
    logic        is_load, is_store, misaligned, active, start;
    logic [1:0]  req_size;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        req_size   = 2'd2;
        req_wstrb  = 4'b0000;
        req_wdata  = 32'h0;
        case (opM)
            OP_LB, OP_LBU: begin
                is_load  = 1'b1;
                req_size = 2'd0;
            end
            OP_LH, OP_LHU: begin
                is_load    = 1'b1;
                req_size   = 2'd1;
                misaligned = addrM[0];
            end
            OP_LW: begin
                is_load    = 1'b1;
                misaligned = |addrM[1:0];
            end
            OP_SB: begin
                is_store  = 1'b1;
                req_size  = 2'd0;
                req_wstrb = 4'b0001 << addrM[1:0];
                req_wdata = {4{writedataM[7:0]}};
            end
            OP_SH: begin
                is_store   = 1'b1;
                req_size   = 2'd1;
                misaligned = addrM[0];
                req_wstrb  = addrM[1] ? 4'b1100 : 4'b0011;
                req_wdata  = {2{writedataM[15:0]}};
            end
            OP_SW: begin
                is_store   = 1'b1;
                misaligned = |addrM[1:0];
                req_wstrb  = 4'b1111;
                req_wdata  = writedataM;
            end
            default: ;
        endcase
    end

    assign active = memvalidM & ~flushM;
    assign adelM  = active & is_load & misaligned;
    assign adesM  = active & is_store & misaligned;
    assign start  = active & (is_load | is_store) & ~misaligned;

    // Latched request: the bus sees these, never the live MEM-stage inputs.
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;

    // Lane select and extension of returned read data.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    always_comb begin
        rd_byte  = 8'h0;
        load_val = 32'h0;
        case (addr_q[1:0])
            2'd0: rd_byte = bus.data_rdata[7:0];
            2'd1: rd_byte = bus.data_rdata[15:8];
            2'd2: rd_byte = bus.data_rdata[23:16];
            default: rd_byte = bus.data_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        case (op_q)
            OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_val = {24'h0, rd_byte};
            OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_val = {16'h0, rd_half};
            default: load_val = bus.data_rdata;
        endcase
    end

    // A completion only counts when the stage was not flushed in that cycle.
    logic complete;
    assign complete = bus.data_data_ok & ~flushM &
                      (((state == S_REQ) & bus.data_addr_ok) | (state == S_WAIT));

    always_comb begin
        state_next = state;
        stallM     = 1'b0;
        case (state)
            S_IDLE: begin
                stallM = start;
                if (start) state_next = S_REQ;
            end
            S_REQ: begin
                stallM = 1'b1;
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) state_next = flushM ? S_IDLE : S_DONE;
                    else                  state_next = S_WAIT;
                end else if (flushM) begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                stallM = 1'b1;
                if (bus.data_data_ok) state_next = flushM ? S_IDLE : S_DONE;
                else if (flushM)      state_next = S_DRAIN;
            end
            S_DONE: begin
                // Release for one cycle; always back to IDLE so the retiring
                // instruction cannot start a second transaction.
                state_next = S_IDLE;
            end
            S_DRAIN: begin
                // A new instruction must wait until the orphaned response is gone.
                stallM = memvalidM;
                if (bus.data_data_ok) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= 6'h0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            size_q      <= 2'd0;
            wstrb_q     <= 4'b0000;
            wdata_q     <= 32'h0;
            loadresultM <= 32'h0;
        end else begin
            state <= state_next;
            if ((state == S_IDLE) && start) begin
                op_q    <= opM;
                addr_q  <= addrM;
                wr_q    <= is_store;
                size_q  <= req_size;
                wstrb_q <= req_wstrb;
                wdata_q <= req_wdata;
            end
            if (complete && !wr_q) loadresultM <= load_val;
        end
    end

    assign bus.data_req   = (state == S_REQ);
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_wstrb = wstrb_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;
    assign state_dbg      = state;
endmodule
